// File: rtl/alu_pkg.sv
// Shared ALU control encodings, R-type funct codes and multiply/divide sequencer states.
// Latency: n/a (constants only).
// Backpressure: n/a.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_SLTU = 4'd8;
  localparam logic [3:0] ALU_NOR  = 4'd12;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_RTYPE = 2'd2;
  localparam logic [1:0] ALUOP_SLT   = 2'd3;

  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
  localparam logic [5:0] FUNCT_ADD   = 6'h20;
  localparam logic [5:0] FUNCT_ADDU  = 6'h21;
  localparam logic [5:0] FUNCT_SUB   = 6'h22;
  localparam logic [5:0] FUNCT_SUBU  = 6'h23;
  localparam logic [5:0] FUNCT_AND   = 6'h24;
  localparam logic [5:0] FUNCT_OR    = 6'h25;
  localparam logic [5:0] FUNCT_NOR   = 6'h27;
  localparam logic [5:0] FUNCT_SLT   = 6'h2A;
  localparam logic [5:0] FUNCT_SLTU  = 6'h2B;

  localparam logic [1:0] HILO_ALU = 2'd0;
  localparam logic [1:0] HILO_HI  = 2'd1;
  localparam logic [1:0] HILO_LO  = 2'd2;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/muldiv_seq.sv
// Iterative radix-2 multiply / restoring divide owning HI/LO.
// Latency: launch cycle + DATA_W step cycles + one DONE cycle; HI/LO update on the edge leaving DONE.
// Backpressure: stall asserted in the launch cycle and all of RUN; starts ignored while busy.
module muldiv_seq
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              signed_op,
  input  logic              div_op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              stall,
  output logic              busy,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  md_state_e state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] acc_hi, acc_lo, opnd_b;
  logic              is_div, neg_ab, neg_a, div0;

  logic              launch, last_step;
  logic              a_neg, b_neg;
  logic [DATA_W-1:0] a_abs, b_abs;
  logic [DATA_W:0]   mul_sum, rem_sh, rem_diff;
  logic              rem_ge;
  logic [DATA_W-1:0] rem_new;
  logic [2*DATA_W-1:0] prod, prod_s;
  logic [DATA_W-1:0] quot_res, rem_res, hi_res, lo_res;

  // rst_n gates launch so stall drops immediately while reset is held
  assign launch    = start && rst_n && (state == MD_IDLE);
  assign last_step = (cnt == CNT_LAST);
  assign stall     = launch || (state == MD_RUN);
  assign busy      = (state != MD_IDLE);

  assign a_neg = signed_op && a[DATA_W-1];
  assign b_neg = signed_op && b[DATA_W-1];
  assign a_abs = a_neg ? -a : a;
  assign b_abs = b_neg ? -b : b;

  assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_b} : '0);
  assign rem_sh   = {acc_hi, acc_lo[DATA_W-1]};
  assign rem_diff = rem_sh - {1'b0, opnd_b};
  assign rem_ge   = (rem_sh >= {1'b0, opnd_b});
  assign rem_new  = rem_ge ? rem_diff[DATA_W-1:0] : rem_sh[DATA_W-1:0];

  // With a zero divisor the remainder path rebuilds |dividend|, so only LO needs overriding
  assign prod     = {acc_hi, acc_lo};
  assign prod_s   = neg_ab ? -prod : prod;
  assign quot_res = div0 ? '1 : (neg_ab ? -acc_lo : acc_lo);
  assign rem_res  = neg_a ? -acc_hi : acc_hi;
  assign hi_res   = is_div ? rem_res  : prod_s[2*DATA_W-1:DATA_W];
  assign lo_res   = is_div ? quot_res : prod_s[DATA_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MD_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MD_IDLE: if (launch) state_nxt = MD_RUN;
      MD_RUN:  if (last_step) state_nxt = MD_DONE;
      MD_DONE: state_nxt = MD_IDLE;
      default: state_nxt = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd_b <= '0;
      is_div <= 1'b0;
      neg_ab <= 1'b0;
      neg_a  <= 1'b0;
      div0   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (launch) begin
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= a_abs;
            opnd_b <= b_abs;
            is_div <= div_op;
            neg_ab <= a_neg ^ b_neg;
            neg_a  <= a_neg;
            div0   <= div_op && (b == '0);
          end
        end
        MD_RUN: begin
          cnt <= last_step ? '0 : cnt + 1'b1;
          if (is_div) begin
            acc_hi <= rem_new;
            acc_lo <= {acc_lo[DATA_W-2:0], rem_ge};
          end else begin
            {acc_hi, acc_lo} <= {mul_sum, acc_lo[DATA_W-1:1]};
          end
        end
        MD_DONE: begin
          hi <= hi_res;
          lo <= lo_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_ctrl_muldiv.sv
// EX-stage ALU control decode plus optional mul/div sequencer (enabled by ALU_CTRL_MULDIV_EN).
// Latency: decode is combinational; mul/div result lands in HI/LO DATA_W+2 cycles after launch.
// Backpressure: stall freezes PC/IF/ID/EX for DATA_W+1 cycles per mul/div; none when disabled.
module alu_ctrl_muldiv
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        alu_op,
  input  logic [5:0]        funct,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic [1:0]        hilo_sel,
  output logic              stall,
  output logic              busy,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  logic [3:0] ctrl_code;

  always_comb begin
    ctrl_code = ALU_AND;
    hilo_sel  = HILO_ALU;
    case (alu_op)
      ALUOP_ADD: ctrl_code = ALU_ADD;
      ALUOP_SUB: ctrl_code = ALU_SUB;
      ALUOP_SLT: ctrl_code = ALU_SLT;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD, FUNCT_ADDU: ctrl_code = ALU_ADD;
          FUNCT_SUB, FUNCT_SUBU: ctrl_code = ALU_SUB;
          FUNCT_AND:             ctrl_code = ALU_AND;
          FUNCT_OR:              ctrl_code = ALU_OR;
          FUNCT_NOR:             ctrl_code = ALU_NOR;
          FUNCT_SLT:             ctrl_code = ALU_SLT;
          FUNCT_SLTU:            ctrl_code = ALU_SLTU;
`ifdef ALU_CTRL_MULDIV_EN
          FUNCT_MFHI:            hilo_sel  = HILO_HI;
          FUNCT_MFLO:            hilo_sel  = HILO_LO;
`endif
          default:               ctrl_code = ALU_AND;
        endcase
      end
      default: ctrl_code = ALU_AND;
    endcase
  end

  assign alu_ctrl = CTRL_W'(ctrl_code);

`ifdef ALU_CTRL_MULDIV_EN
  logic md_op;

  assign md_op = ex_valid && (alu_op == ALUOP_RTYPE) &&
                 (funct inside {FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU});

  // funct[0] clear selects the signed variant, funct[1] selects divide
  muldiv_seq #(
    .DATA_W (DATA_W)
  ) u_muldiv_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (md_op),
    .signed_op (~funct[0]),
    .div_op    (funct[1]),
    .a         (rs_val),
    .b         (rt_val),
    .stall     (stall),
    .busy      (busy),
    .hi        (hi),
    .lo        (lo)
  );
`else
  logic unused_md_inputs;

  assign unused_md_inputs = ^{clk, rst_n, ex_valid, rs_val, rt_val};
  assign stall = 1'b0;
  assign busy  = 1'b0;
  assign hi    = '0;
  assign lo    = '0;
`endif

endmodule
